// File: rtl/fetch_pc_pipe.sv
// Fetch PC owner and F->D->X pipeline registers for the RISC-V front end.
// A one-cycle BOOT state primes the synchronous instruction memory after reset.
module fetch_pc_pipe #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    input  logic        redirect,
    input  logic        stall,
    input  logic [31:0] imem_dout,
    output logic [31:0] imem_addr,
    output logic        imem_en,
    output logic [31:0] pc,
    output logic [31:0] pc_d,
    output logic [31:0] inst_d,
    output logic        valid_d,
    output logic [31:0] pc_x,
    output logic [31:0] inst_x,
    output logic        valid_x,
    output logic [31:0] inst_count
);
    typedef enum logic {BOOT, RUN} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
    } stage_t;

    localparam stage_t BUBBLE = '{pc: 32'd0, inst: NOP, valid: 1'b0};

    state_t      state;
    logic [31:0] pc_q;
    stage_t      d_q, x_q;
    logic [31:0] count_q;

    // Stall re-reads the current PC so imem_dout stays paired with pc.
    always_comb begin
        imem_addr = next_pc;
        if (state == BOOT)   imem_addr = pc_q;
        else if (redirect)   imem_addr = next_pc;
        else if (stall)      imem_addr = pc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= BOOT;
            pc_q    <= RESET_PC;
            d_q     <= BUBBLE;
            x_q     <= BUBBLE;
            count_q <= 32'd0;
        end else begin
            if (x_q.valid) count_q <= count_q + 32'd1;
            case (state)
                BOOT: begin
                    state <= RUN;
                    d_q   <= BUBBLE;
                    x_q   <= BUBBLE;
                end
                default: begin
                    if (redirect) begin
                        pc_q <= next_pc;
                        d_q  <= BUBBLE;
                        x_q  <= BUBBLE;
                    end else if (stall) begin
                        x_q  <= BUBBLE;
                    end else begin
                        pc_q <= next_pc;
                        d_q  <= '{pc: pc_q, inst: imem_dout, valid: 1'b1};
                        x_q  <= d_q;
                    end
                end
            endcase
        end
    end

    assign imem_en    = 1'b1;
    assign pc         = pc_q;
    assign pc_d       = d_q.pc;
    assign inst_d     = d_q.inst;
    assign valid_d    = d_q.valid;
    assign pc_x       = x_q.pc;
    assign inst_x     = x_q.inst;
    assign valid_x    = x_q.valid;
    assign inst_count = count_q;
endmodule

// File: tb/tb_fetch_pc_pipe.sv
// Directed table-driven bench for fetch_pc_pipe; memory returns addr>>2 as the instruction word.
module tb_fetch_pc_pipe;
    localparam logic [31:0] R   = 32'h4000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0, stall = 1'b0, use_tgt = 1'b0;
    logic [31:0] tgt = 32'd0;
    logic [31:0] next_pc, imem_dout, imem_addr, pc, pc_d, inst_d, pc_x, inst_x, inst_count;
    logic        imem_en, valid_d, valid_x;

    int checks = 0, errors = 0;

    fetch_pc_pipe #(.RESET_PC(R), .NOP(NOP)) dut (
        .clk(clk), .rst(rst), .next_pc(next_pc), .redirect(redirect), .stall(stall),
        .imem_dout(imem_dout), .imem_addr(imem_addr), .imem_en(imem_en), .pc(pc),
        .pc_d(pc_d), .inst_d(inst_d), .valid_d(valid_d),
        .pc_x(pc_x), .inst_x(inst_x), .valid_x(valid_x), .inst_count(inst_count)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory, word = address>>2.
    always @(posedge clk) if (imem_en) imem_dout <= imem_addr >> 2;

    assign next_pc = use_tgt ? tgt : pc + 32'd4;

    typedef struct {
        logic        stall, redirect, use_tgt;
        logic [31:0] tgt, pc, pc_d, pc_x;
        logic        vd, vx;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] t,
                                input logic [31:0] epc, input logic [31:0] epd,
                                input logic [31:0] epx, input logic vd, input logic vx);
        vec_t v;
        v.stall = s; v.redirect = r; v.use_tgt = (t != 32'd0); v.tgt = t;
        v.pc = epc; v.pc_d = epd; v.pc_x = epx; v.vd = vd; v.vx = vx;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " pc"}, pc, R);
        chk({tag, " imem_addr"}, imem_addr, R);
        chk({tag, " imem_en"}, {31'd0, imem_en}, 32'd1);
        chk({tag, " pc_d"}, pc_d, 32'd0);
        chk({tag, " inst_d"}, inst_d, NOP);
        chk({tag, " valid_d"}, {31'd0, valid_d}, 32'd0);
        chk({tag, " pc_x"}, pc_x, 32'd0);
        chk({tag, " inst_x"}, inst_x, NOP);
        chk({tag, " valid_x"}, {31'd0, valid_x}, 32'd0);
        chk({tag, " inst_count"}, inst_count, 32'd0);
    endtask

    initial begin
        logic [31:0] exp_addr, prev_pc, cnt_m;
        logic        prev_vx;

        // Row 0 is the BOOT cycle; its redirect/target must be ignored.
        tbl[0]  = mk(0, 1, 32'h0000_1234, R,         0,         0,         0, 0);
        tbl[1]  = mk(0, 0, 0,             R+32'h04,  R,         0,         1, 0);
        tbl[2]  = mk(0, 0, 0,             R+32'h08,  R+32'h04,  R,         1, 1);
        tbl[3]  = mk(0, 0, 0,             R+32'h0C,  R+32'h08,  R+32'h04,  1, 1);
        tbl[4]  = mk(1, 0, 0,             R+32'h0C,  R+32'h08,  0,         1, 0);
        tbl[5]  = mk(1, 0, 0,             R+32'h0C,  R+32'h08,  0,         1, 0);
        tbl[6]  = mk(1, 0, 0,             R+32'h0C,  R+32'h08,  0,         1, 0);
        tbl[7]  = mk(0, 0, 0,             R+32'h10,  R+32'h0C,  R+32'h08,  1, 1);
        tbl[8]  = mk(0, 0, 0,             R+32'h14,  R+32'h10,  R+32'h0C,  1, 1);
        tbl[9]  = mk(0, 1, R+32'h100,     R+32'h100, 0,         0,         0, 0);
        tbl[10] = mk(0, 0, 0,             R+32'h104, R+32'h100, 0,         1, 0);
        tbl[11] = mk(0, 0, 0,             R+32'h108, R+32'h104, R+32'h100, 1, 1);
        tbl[12] = mk(1, 1, R+32'h200,     R+32'h200, 0,         0,         0, 0);
        tbl[13] = mk(0, 0, 0,             R+32'h204, R+32'h200, 0,         1, 0);
        tbl[14] = mk(1, 0, 0,             R+32'h204, R+32'h200, 0,         1, 0);
        tbl[15] = mk(0, 0, 0,             R+32'h208, R+32'h204, R+32'h200, 1, 1);
        tbl[16] = mk(0, 0, 0,             R+32'h20C, R+32'h208, R+32'h204, 1, 1);
        tbl[17] = mk(0, 0, 0,             R+32'h210, R+32'h20C, R+32'h208, 1, 1);

        step(); step();
        chk_reset("reset");

        rst = 1'b0;
        prev_pc = R; prev_vx = 1'b0; cnt_m = 32'd0;
        for (int i = 0; i < 18; i++) begin
            stall = tbl[i].stall; redirect = tbl[i].redirect;
            use_tgt = tbl[i].use_tgt; tgt = tbl[i].tgt;
            #1;
            if (i == 0 || (tbl[i].stall && !tbl[i].redirect)) exp_addr = prev_pc;
            else exp_addr = tbl[i].use_tgt ? tbl[i].tgt : prev_pc + 32'd4;
            chk($sformatf("row%0d imem_addr", i), imem_addr, exp_addr);
            step();
            if (prev_vx) cnt_m = cnt_m + 32'd1;
            chk($sformatf("row%0d pc", i), pc, tbl[i].pc);
            chk($sformatf("row%0d pc_d", i), pc_d, tbl[i].pc_d);
            chk($sformatf("row%0d valid_d", i), {31'd0, valid_d}, {31'd0, tbl[i].vd});
            chk($sformatf("row%0d inst_d", i), inst_d, tbl[i].vd ? tbl[i].pc_d >> 2 : NOP);
            chk($sformatf("row%0d pc_x", i), pc_x, tbl[i].pc_x);
            chk($sformatf("row%0d valid_x", i), {31'd0, valid_x}, {31'd0, tbl[i].vx});
            chk($sformatf("row%0d inst_x", i), inst_x, tbl[i].vx ? tbl[i].pc_x >> 2 : NOP);
            chk($sformatf("row%0d inst_count", i), inst_count, cnt_m);
            prev_pc = tbl[i].pc; prev_vx = tbl[i].vx;
        end
        stall = 1'b0; redirect = 1'b0; use_tgt = 1'b0;

        // Seven retired so far; three more edges with valid X make ten.
        step(); step(); step();
        chk("run10 inst_count", inst_count, 32'd10);
        chk("run10 pc_x", pc_x, R + 32'h214);

        // Asynchronous reset between edges.
        #2 rst = 1'b1;
        #1 chk_reset("midrst");
        rst = 1'b0;

        step();
        chk("reboot valid_d", {31'd0, valid_d}, 32'd0);
        step();
        chk("reboot pc_d", pc_d, R);
        step();
        chk("reboot pc_x", pc_x, R);
        chk("reboot count", inst_count, 32'd0);

        force dut.count_q = 32'hFFFF_FFFE;
        #1 release dut.count_q;
        step();
        chk("wrap pre", inst_count, 32'hFFFF_FFFF);
        chk("wrap pc_x", pc_x, R + 32'h4);
        step();
        chk("wrap zero", inst_count, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
